pmem_responder: RTL and testbench

//  Responder (memory side) of the 256-bit line pmem protocol driven by the cache

---
 rtl/pmem_pkg.sv | 19 +
 rtl/line_store.sv | 55 +++++
 rtl/pmem_responder.sv | 142 ++++++++++++++
 tb/tb_pmem_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared types and constants for the pmem line responder
//
// Purpose: line type, line geometry constants and FSM state encoding used by
//          pmem_responder and line_store.
// Ports:   none (package).
package pmem_pkg;

  typedef logic [255:0] line_t;

  localparam int OFFSET_BITS = 5;
  localparam int LINE_BYTES  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_e;

endpackage

// File: rtl/line_store.sv
// rtl/line_store.sv - line-wide storage array with resettable valid bits
//
// Purpose: 2^INDEX_BITS lines of storage with one write port and a
//          combinational read port. Only the valid bits are reset; the data
//          array keeps whatever it held, and an invalid line reads back as
//          rvalid=0 so the caller can substitute zero.
// Ports:
//   clk     in   1           clock
//   rst     in   1           synchronous active-high reset (valid bits only)
//   we      in   1           write enable, commits wdata at waddr on posedge
//   waddr   in   INDEX_BITS  write line index
//   wdata   in   256         write line
//   raddr   in   INDEX_BITS  read line index
//   rdata   out  256         stored line at raddr (unqualified)
//   rvalid  out  1           line at raddr has been written since reset
module line_store
  import pmem_pkg::*;
#(
  parameter int INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] waddr,
  input  line_t                 wdata,
  input  logic [INDEX_BITS-1:0] raddr,
  output line_t                 rdata,
  output logic                  rvalid
);

  localparam int LINES = 1 << INDEX_BITS;

  line_t            mem [LINES];
  logic [LINES-1:0] valid;

  // Data array has no reset; a write coinciding with reset is dropped so an
  // in-flight op never lands.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[waddr] <= 1'b1;
    end
  end

  assign rdata  = mem[raddr];
  assign rvalid = valid[raddr];

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency memory-side responder for 256-bit pmem lines
//
// Purpose: accepts one line read or write from IDLE, waits LATENCY cycles from
//          the request cycle, then pulses pmem_resp for one cycle. Reads return
//          the stored line (zero if never written since reset); writes commit at
//          the end of the response cycle. Read and write requested together in
//          IDLE set a sticky protocol_error and are not accepted.
// Ports:
//   clk            in   1    clock
//   rst            in   1    synchronous active-high reset
//   pmem_read      in   1    line read request, held until pmem_resp
//   pmem_write     in   1    line write request, held until pmem_resp
//   pmem_address   in   32   byte address, bits [4:0] ignored
//   pmem_wdata     in   256  write line, sampled in the accept cycle
//   pmem_resp      out  1    one-cycle completion pulse
//   pmem_rdata     out  256  read line, held until the next read response
//   protocol_error out  1    sticky read+write conflict flag
//   rd_count       out  32   completed reads (wrapping)
//   wr_count       out  32   completed writes (wrapping)
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  line_t       pmem_wdata,
  output logic        pmem_resp,
  output line_t       pmem_rdata,
  output logic        protocol_error,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  // BUSY counts down from LATENCY-2 to 0; LATENCY=1 skips BUSY entirely.
  localparam logic [15:0] CNT_INIT = 16'((LATENCY > 1) ? (LATENCY - 2) : 0);

  pmem_state_e           state;
  logic [15:0]           cnt;
  logic                  op_write;
  logic [INDEX_BITS-1:0] idx;
  line_t                 wdata_q;

  logic [INDEX_BITS-1:0] req_idx;
  logic [INDEX_BITS-1:0] rd_idx;
  line_t                 store_rdata;
  logic                  store_rvalid;
  line_t                 store_line;
  logic                  store_we;

  assign req_idx = pmem_address[OFFSET_BITS +: INDEX_BITS];

  // Only the line-index field of the address matters; the offset and the
  // aliasing high bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pmem_address[31:OFFSET_BITS+INDEX_BITS],
                              pmem_address[OFFSET_BITS-1:0]};

  // The read port looks at the live request index only when IDLE jumps
  // straight to RESP (LATENCY=1); otherwise the latched index is used.
  assign rd_idx     = (state == IDLE) ? req_idx : idx;
  assign store_line = store_rvalid ? store_rdata : '0;
  assign store_we   = (state == RESP) && op_write;

  line_store #(
    .INDEX_BITS(INDEX_BITS)
  ) u_store (
    .clk    (clk),
    .rst    (rst),
    .we     (store_we),
    .waddr  (idx),
    .wdata  (wdata_q),
    .raddr  (rd_idx),
    .rdata  (store_rdata),
    .rvalid (store_rvalid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      op_write       <= 1'b0;
      idx            <= '0;
      wdata_q        <= '0;
      pmem_resp      <= 1'b0;
      pmem_rdata     <= '0;
      protocol_error <= 1'b0;
      rd_count       <= '0;
      wr_count       <= '0;
    end else begin
      pmem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (pmem_read && pmem_write) begin
            protocol_error <= 1'b1;
          end else if (pmem_read || pmem_write) begin
            op_write <= pmem_write;
            idx      <= req_idx;
            wdata_q  <= pmem_wdata;
            cnt      <= CNT_INIT;
            if (LATENCY > 1) begin
              state <= BUSY;
            end else begin
              // Response data is registered on entry to RESP so it is
              // valid for the whole pulse cycle.
              state     <= RESP;
              pmem_resp <= 1'b1;
              if (pmem_read) begin
                pmem_rdata <= store_line;
              end
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state     <= RESP;
            pmem_resp <= 1'b1;
            if (!op_write) begin
              pmem_rdata <= store_line;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          if (op_write) begin
            wr_count <= wr_count + 32'd1;
          end else begin
            rd_count <= rd_count + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - randomized self-checking bench for pmem_responder
module tb_pmem_responder;
  import pmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [31:0] addr_a, addr_b;
  line_t       wdata_a, wdata_b;
  logic        resp_a, resp_b, err_a, err_b;
  line_t       rdata_a, rdata_b;
  logic [31:0] rdc_a, wrc_a, rdc_b, wrc_b;

  pmem_responder #(.INDEX_BITS(8), .LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .pmem_read(rd_a), .pmem_write(wr_a),
    .pmem_address(addr_a), .pmem_wdata(wdata_a), .pmem_resp(resp_a),
    .pmem_rdata(rdata_a), .protocol_error(err_a), .rd_count(rdc_a), .wr_count(wrc_a)
  );

  pmem_responder #(.INDEX_BITS(8), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .pmem_read(rd_b), .pmem_write(wr_b),
    .pmem_address(addr_b), .pmem_wdata(wdata_b), .pmem_resp(resp_b),
    .pmem_rdata(rdata_b), .protocol_error(err_b), .rd_count(rdc_b), .wr_count(wrc_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model of dut_a: a plain line array indexed by address[12:5].
  line_t       model_mem [256];
  bit          model_valid [256];
  int unsigned model_rd, model_wr;

  bit    sel = 1'b0;
  logic  obs_resp;
  line_t obs_rdata;
  assign obs_resp  = sel ? resp_b : resp_a;
  assign obs_rdata = sel ? rdata_b : rdata_a;

  function automatic line_t rand_line();
    line_t r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic line_t model_read(input logic [31:0] a);
    int i;
    i = int'(a / 32) % 256;
    return model_valid[i] ? model_mem[i] : '0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input line_t d);
    int i;
    i = int'(a / 32) % 256;
    model_mem[i]   = d;
    model_valid[i] = 1'b1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) model_valid[i] = 1'b0;
    model_rd = 0;
    model_wr = 0;
  endfunction

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input line_t d);
    if (sel) begin
      rd_b = r; wr_b = w; addr_b = a; wdata_b = d;
    end else begin
      rd_a = r; wr_a = w; addr_a = a; wdata_a = d;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Starts at a negedge in an IDLE cycle; returns cycles to resp (-1 on
  // timeout), the read data seen with resp, and resp one cycle later.
  task automatic txn(input bit is_w, input logic [31:0] a, input line_t d, input bit mangle,
                     output int lat, output line_t rd, output logic resp_after);
    line_t junk;
    lat = -1;
    rd  = '0;
    drive(!is_w, is_w, a, d);
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (obs_resp) begin
        lat = n;
        rd  = obs_rdata;
        break;
      end
      if (mangle && n == 1) begin
        junk = rand_line();
        drive(1'b0, 1'b0, $urandom, junk);
      end
    end
    drive(1'b0, 1'b0, 32'h0, '0);
    @(posedge clk);
    @(negedge clk);
    resp_after = obs_resp;
  endtask

  task automatic test_reset();
    pulse_reset();
    tests++;
    if (resp_a !== 1'b0 || err_a !== 1'b0 || rdata_a !== '0) begin
      fails++;
      $display("FAIL reset_outputs: resp=%b err=%b rdata=%h required 0/0/0", resp_a, err_a, rdata_a);
    end
    tests++;
    if (rdc_a !== 32'd0 || wrc_a !== 32'd0 || resp_b !== 1'b0) begin
      fails++;
      $display("FAIL reset_counts: rd=%0d wr=%0d resp_b=%b required 0/0/0", rdc_a, wrc_a, resp_b);
    end
  endtask

  task automatic test_basic_read();
    int lat; line_t rd; logic ra;
    txn(1'b0, 32'h0000_0100, '0, 1'b0, lat, rd, ra);
    model_rd++;
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL read_latency: got %0d required 4", lat); end
    tests++;
    if (rd !== '0) begin fails++; $display("FAIL read_unwritten: got %h required 0", rd); end
    tests++;
    if (rdc_a !== 32'(model_rd)) begin fails++; $display("FAIL rd_count_1: got %0d required %0d", rdc_a, model_rd); end
  endtask

  task automatic test_write_read();
    int lat; line_t rd; logic ra;
    line_t d;
    d = {8{32'hDEADBEEF}};
    txn(1'b1, 32'h0000_0020, d, 1'b0, lat, rd, ra);
    model_write(32'h20, d); model_wr++;
    tests++;
    if (ra !== 1'b0) begin fails++; $display("FAIL resp_double_write: resp after pulse=%b required 0", ra); end
    txn(1'b0, 32'h0000_003C, '0, 1'b0, lat, rd, ra);
    model_rd++;
    tests++;
    if (rd !== d) begin fails++; $display("FAIL raw_same_line: got %h required %h", rd, d); end
    tests++;
    if (ra !== 1'b0) begin fails++; $display("FAIL resp_double_read: resp after pulse=%b required 0", ra); end
    tests++;
    if (wrc_a !== 32'(model_wr) || rdc_a !== 32'(model_rd)) begin
      fails++;
      $display("FAIL counts_rw: rd=%0d wr=%0d required %0d/%0d", rdc_a, wrc_a, model_rd, model_wr);
    end
  endtask

  task automatic test_alias();
    int lat; line_t rd; logic ra;
    txn(1'b1, 32'h0000_2000, {256{1'b1}}, 1'b0, lat, rd, ra);
    model_write(32'h2000, {256{1'b1}}); model_wr++;
    txn(1'b0, 32'h0000_0000, '0, 1'b0, lat, rd, ra);
    model_rd++;
    tests++;
    if (rd !== {256{1'b1}}) begin fails++; $display("FAIL alias_read: got %h required all ones", rd); end
  endtask

  task automatic test_drop();
    int lat; line_t rd; logic ra;
    line_t d;
    d = rand_line();
    txn(1'b1, 32'h0000_0040, d, 1'b1, lat, rd, ra);
    model_write(32'h40, d); model_wr++;
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL drop_latency: got %0d required 4", lat); end
    txn(1'b0, 32'h0000_0040, '0, 1'b0, lat, rd, ra);
    model_rd++;
    tests++;
    if (rd !== d) begin fails++; $display("FAIL drop_commit: got %h required %h", rd, d); end
  endtask

  task automatic test_protocol_error();
    int resp_seen;
    resp_seen = 0;
    drive(1'b1, 1'b1, 32'h0000_0080, rand_line());
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_a) resp_seen++;
    end
    tests++;
    if (resp_seen != 0) begin fails++; $display("FAIL conflict_no_resp: %0d resp cycles required 0", resp_seen); end
    tests++;
    if (err_a !== 1'b1) begin fails++; $display("FAIL conflict_flag: got %b required 1", err_a); end
    drive(1'b0, 1'b0, 32'h0, '0);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    tests++;
    if (err_a !== 1'b1) begin fails++; $display("FAIL conflict_sticky: got %b required 1", err_a); end
    pulse_reset();
    tests++;
    if (err_a !== 1'b0) begin fails++; $display("FAIL conflict_reset: got %b required 0", err_a); end
  endtask

  task automatic test_reset_busy();
    int lat; line_t rd; logic ra;
    int resp_seen;
    line_t d;
    d = rand_line();
    txn(1'b1, 32'h0000_0020, d, 1'b0, lat, rd, ra);
    model_write(32'h20, d); model_wr++;
    drive(1'b0, 1'b1, 32'h0000_0060, rand_line());
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    resp_seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_a) resp_seen++;
    end
    tests++;
    if (resp_seen != 0) begin fails++; $display("FAIL busy_reset_resp: %0d resp cycles required 0", resp_seen); end
    txn(1'b0, 32'h0000_0060, '0, 1'b0, lat, rd, ra);
    model_rd++;
    tests++;
    if (rd !== '0) begin fails++; $display("FAIL busy_reset_discard: got %h required 0", rd); end
    txn(1'b0, 32'h0000_0020, '0, 1'b0, lat, rd, ra);
    model_rd++;
    tests++;
    if (rd !== '0) begin fails++; $display("FAIL reset_clears_valid: got %h required 0", rd); end
    tests++;
    if (wrc_a !== 32'(model_wr) || rdc_a !== 32'(model_rd)) begin
      fails++;
      $display("FAIL counts_after_reset: rd=%0d wr=%0d required %0d/%0d", rdc_a, wrc_a, model_rd, model_wr);
    end
  endtask

  task automatic test_random();
    int lat; line_t rd; logic ra;
    int bad_lat, bad_data, bad_double;
    logic [31:0] a;
    line_t d, exp_line;
    bit is_w, mangle;
    bad_lat = 0; bad_data = 0; bad_double = 0;
    for (int k = 0; k < 60; k++) begin
      is_w   = ($urandom_range(0, 1) == 1);
      mangle = ($urandom_range(0, 3) == 0);
      a      = {$urandom_range(0, 7), 19'h0, 3'($urandom_range(0, 7)) , 5'($urandom)};
      d      = rand_line();
      exp_line = model_read(a);
      txn(is_w, a, d, mangle, lat, rd, ra);
      if (lat != 4) bad_lat++;
      if (ra !== 1'b0) bad_double++;
      if (is_w) begin
        model_write(a, d); model_wr++;
      end else begin
        model_rd++;
        if (rd !== exp_line) begin
          bad_data++;
          $display("FAIL random_read: addr=%h got %h required %h", a, rd, exp_line);
        end
      end
    end
    tests++;
    if (bad_lat != 0) begin fails++; $display("FAIL random_latency: %0d bad latencies required 0", bad_lat); end
    tests++;
    if (bad_data != 0) fails++;
    tests++;
    if (bad_double != 0) begin fails++; $display("FAIL random_spacing: %0d double pulses required 0", bad_double); end
    tests++;
    if (wrc_a !== 32'(model_wr) || rdc_a !== 32'(model_rd)) begin
      fails++;
      $display("FAIL random_counts: rd=%0d wr=%0d required %0d/%0d", rdc_a, wrc_a, model_rd, model_wr);
    end
  endtask

  task automatic test_latency1();
    int lat; line_t rd; logic ra;
    line_t d;
    d = rand_line();
    sel = 1'b1;
    txn(1'b1, 32'h0000_0020, d, 1'b0, lat, rd, ra);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL lat1_write_latency: got %0d required 1", lat); end
    txn(1'b0, 32'h0000_0020, '0, 1'b0, lat, rd, ra);
    tests++;
    if (lat !== 1 || rd !== d) begin fails++; $display("FAIL lat1_read: lat=%0d data=%h required 1/%h", lat, rd, d); end
    tests++;
    if (ra !== 1'b0) begin fails++; $display("FAIL lat1_spacing: resp after pulse=%b required 0", ra); end
    txn(1'b0, 32'h0000_1000, '0, 1'b0, lat, rd, ra);
    tests++;
    if (rd !== '0) begin fails++; $display("FAIL lat1_unwritten: got %h required 0", rd); end
    tests++;
    if (rdc_b !== 32'd2 || wrc_b !== 32'd1) begin
      fails++;
      $display("FAIL lat1_counts: rd=%0d wr=%0d required 2/1", rdc_b, wrc_b);
    end
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
    rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
    model_reset();
    test_reset();
    test_basic_read();
    test_write_read();
    test_alias();
    test_drop();
    test_protocol_error();
    test_reset_busy();
    test_random();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
